// File: rtl/pattern_pkg.sv
// Shared state encoding, default geometry and helpers for the pattern buffer loader.
package pattern_pkg;

  localparam int DEF_BUFFER_WIDTH = 8;
  localparam int DEF_BUFFER_SIZE  = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_e;

  function automatic logic is_rise(input logic prev_v, input logic next_v);
    return (~prev_v) & next_v;
  endfunction

endpackage

// File: rtl/pattern_loader_bitclk.sv
// Phase timer for the serial clock: counts clk cycles within a pb_sclk half-period
// and flags the last cycle of each phase.
module pattern_loader_bitclk #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic phase_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end_o = run_i && (cnt_q == LAST);

  // Restart the count at every phase boundary and whenever shifting is paused.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || phase_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// Serial frame loader for an external pattern buffer, MSB first, with optional
// read-back of the displaced buffer contents (enabled by defining READBACK_EN).
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE,
  parameter int CLK_DIV      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BUFFER_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    pb_sclk,
  output logic                    pb_ssel,
  output logic                    pb_sin,
  input  logic                    pb_sout,
  output logic [BUFFER_WIDTH-1:0] rd_data,
  output logic                    rd_valid
);

  localparam int BYTE_W = $clog2(BUFFER_SIZE + 1);
  localparam int BIT_W  = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BUFFER_WIDTH - 1);
  localparam logic [BYTE_W-1:0] BYTE_FULL = BYTE_W'(BUFFER_SIZE);

  state_e                  state_q, state_d;
  logic [BYTE_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BUFFER_WIDTH-1:0] shreg_q, shreg_d;
  logic                    sclk_q, sclk_d;
  logic                    ssel_q, ssel_d;
  logic                    sin_q, sin_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    run_s;
  logic                    phase_end_s;

  assign run_s = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

  pattern_loader_bitclk #(
    .CLK_DIV(CLK_DIV)
  ) u_bitclk (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run_s),
    .phase_end_o(phase_end_s)
  );

  // Next-state logic; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    sin_d      = sin_q;

    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        bit_cnt_d  = '0;
        if (start) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid && ready_q) begin
          shreg_d    = {in_data[BUFFER_WIDTH-2:0], 1'b0};
          sin_d      = in_data[BUFFER_WIDTH-1];
          bit_cnt_d  = BIT_LAST;
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          state_d    = SHIFT_LO;
        end else begin
          state_d = LOAD;
        end
      end
      SHIFT_LO: begin
        if (phase_end_s) begin
          state_d = SHIFT_HI;
        end else begin
          state_d = SHIFT_LO;
        end
      end
      SHIFT_HI: begin
        // pb_sin only changes as pb_sclk falls, keeping it stable across the rise.
        if (!phase_end_s) begin
          state_d = SHIFT_HI;
        end else if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
          sin_d     = shreg_q[BUFFER_WIDTH-1];
          shreg_d   = {shreg_q[BUFFER_WIDTH-2:0], 1'b0};
          state_d   = SHIFT_LO;
        end else if (byte_cnt_q < BYTE_FULL) begin
          state_d = LOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        sin_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d == LOAD) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    ssel_d  = busy_d;
    ready_d = (state_d == LOAD);
    sclk_d  = (state_d == SHIFT_HI);
    done_d  = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      ssel_q     <= 1'b0;
      sin_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      ssel_q     <= ssel_d;
      sin_q      <= sin_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pb_sclk  = sclk_q;
  assign pb_ssel  = ssel_q;
  assign pb_sin   = sin_q;

`ifdef READBACK_EN
  logic [BUFFER_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [BIT_W-1:0]        rd_cnt_q, rd_cnt_d;

  // pb_sout is sampled on the edge that raises pb_sclk, i.e. before the buffer shifts.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_cnt_d   = rd_cnt_q;
    rd_valid_d = 1'b0;
    if (is_rise(sclk_q, sclk_d)) begin
      rd_data_d = {rd_data_q[BUFFER_WIDTH-2:0], pb_sout};
      if (rd_cnt_q == BIT_LAST) begin
        rd_cnt_d   = '0;
        rd_valid_d = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + BIT_W'(1);
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Read-back shift register and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_sout_s;
  assign unused_sout_s = pb_sout;
  assign rd_data       = '0;
  assign rd_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: a CLK_DIV=2 instance driven from a frame table
// plus hand sequences, and a CLK_DIV=1 instance for the fast serial clock case.
module tb_pattern_loader;

  localparam int N = 32;
`ifdef READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, busy, done, pb_sclk, pb_ssel, pb_sin, pb_sout, rd_valid;
  logic [7:0] rd_data;
  logic       start1 = 1'b0;
  logic       in_ready1, busy1, done1, pb_sclk1, pb_ssel1, pb_sin1, pb_sout1, rd_valid1;
  logic [7:0] rd_data1;

  logic [255:0] chain0 = '0, chain1 = '0;
  int edges0 = 0, edges1 = 0;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    string      name;
    logic [7:0] base;
    logic [7:0] step;
    int         stall_after;
    int         stall_len;
    bit         busy_starts;
    bit         preload;
    int         exp_len;
    logic [7:0] exp_b31;
    logic [7:0] exp_b0;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  pattern_loader #(.BUFFER_WIDTH(8), .BUFFER_SIZE(32), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .pb_sclk(pb_sclk), .pb_ssel(pb_ssel),
    .pb_sin(pb_sin), .pb_sout(pb_sout), .rd_data(rd_data), .rd_valid(rd_valid));

  pattern_loader #(.BUFFER_WIDTH(8), .BUFFER_SIZE(32), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_data(8'h5A), .in_valid(1'b1),
    .in_ready(in_ready1), .busy(busy1), .done(done1), .pb_sclk(pb_sclk1), .pb_ssel(pb_ssel1),
    .pb_sin(pb_sin1), .pb_sout(pb_sout1), .rd_data(rd_data1), .rd_valid(rd_valid1));

  // Pattern buffer models: 256-bit shift chains, byte k = chain[8k+7:8k].
  assign pb_sout  = chain0[255];
  assign pb_sout1 = chain1[255];
  always @(posedge pb_sclk) begin
    edges0 <= edges0 + 1;
    if (pb_ssel) chain0 <= {chain0[254:0], pb_sin};
  end
  always @(posedge pb_sclk1) begin
    edges1 <= edges1 + 1;
    if (pb_ssel1) chain1 <= {chain1[254:0], pb_sin1};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] base, input logic [7:0] step,
                           input int stall_after, input int stall_len,
                           input bit busy_starts, input bit preload,
                           output int len, output int ndone, output int stall_bad,
                           output int ssel_bad, output int nedges,
                           output int rv_cnt, output int rv_bad);
    int idx, c, first_acc, done_cyc, stall_cnt, e0;
    idx = 0; c = 0; first_acc = -1; done_cyc = -1; stall_cnt = 0;
    ndone = 0; stall_bad = 0; ssel_bad = 0; rv_cnt = 0; rv_bad = 0;
    e0 = edges0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (done_cyc < 0 && c < 5000) begin
      if (done === 1'b1) begin
        ndone++;
        done_cyc = c;
      end else if (pb_ssel !== 1'b1 || busy !== 1'b1) begin
        ssel_bad++;
      end
      if (rd_valid === 1'b1) rv_cnt++;
      if (RB) begin
        if (preload && rd_valid === 1'b1 && rd_data !== 8'hA5) rv_bad++;
      end else if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
        rv_bad++;
      end
      if (idx < N && idx == stall_after + 1 && stall_cnt < stall_len) begin
        in_valid = 1'b0;
        if (in_ready === 1'b1) begin
          stall_cnt++;
          if (pb_sclk !== 1'b0 || pb_ssel !== 1'b1) stall_bad++;
        end
      end else if (idx < N) begin
        in_valid = 1'b1;
        in_data  = 8'(base + step * idx);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready === 1'b1) begin
        if (first_acc < 0) first_acc = c;
        idx++;
      end
      start = busy_starts && (c % 100 == 40);
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    len = (done_cyc >= 0 && first_acc >= 0) ? done_cyc - first_acc : -1;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    nedges = edges0 - e0;
  endtask

  task automatic check_contents(input string nm, input logic [7:0] base, input logic [7:0] step);
    int nb;
    logic [7:0] e;
    nb = 0;
    for (int k = 0; k < N; k++) begin
      e = 8'(base + step * (N - 1 - k));
      if (chain0[8*k +: 8] !== e) nb++;
    end
    chk({nm, "_contents_bad_bytes"}, nb, 0);
  endtask

  initial begin
    int len, ndone, stall_bad, ssel_bad, nedges, rv_cnt, rv_bad;
    int e0, c, first, dc, tog_bad;
    bit prev_shift;
    logic prev_sclk;

    vecs[0] = '{"ramp",       8'h00, 8'h01, -1,  0, 1'b0, 1'b0, 1056, 8'h00, 8'h1F};
    vecs[1] = '{"stall",      8'h00, 8'h01,  5, 50, 1'b0, 1'b0, 1106, 8'h00, 8'h1F};
    vecs[2] = '{"busy_start", 8'h80, 8'h01, -1,  0, 1'b1, 1'b0, 1056, 8'h80, 8'h9F};
    vecs[3] = '{"readback",   8'h3C, 8'h00, -1,  0, 1'b0, 1'b1, 1056, 8'h3C, 8'h3C};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready, busy, done, pb_sclk, pb_ssel, pb_sin, rd_valid, rd_data}, 64'h0);
    chk("reset_outputs_div1", {in_ready1, busy1, done1, pb_sclk1, pb_ssel1, pb_sin1, rd_valid1, rd_data1}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {in_ready, busy, done, pb_sclk, pb_ssel}, 64'h0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].preload) begin
        chain0 <= {32{8'hA5}};
        @(negedge clk);
      end
      run_frame(vecs[v].base, vecs[v].step, vecs[v].stall_after, vecs[v].stall_len,
                vecs[v].busy_starts, vecs[v].preload,
                len, ndone, stall_bad, ssel_bad, nedges, rv_cnt, rv_bad);
      chk({vecs[v].name, "_len"}, len, vecs[v].exp_len);
      chk({vecs[v].name, "_byte31"}, chain0[255:248], vecs[v].exp_b31);
      chk({vecs[v].name, "_byte0"}, chain0[7:0], vecs[v].exp_b0);
      check_contents(vecs[v].name, vecs[v].base, vecs[v].step);
      chk({vecs[v].name, "_done_pulses"}, ndone, 1);
      chk({vecs[v].name, "_stall_glitches"}, stall_bad, 0);
      chk({vecs[v].name, "_ssel_busy_drops"}, ssel_bad, 0);
      chk({vecs[v].name, "_sclk_edges"}, nedges, 256);
      chk({vecs[v].name, "_rd_pulses"}, rv_cnt, RB ? 32 : 0);
      chk({vecs[v].name, "_rd_data_bad"}, rv_bad, 0);
      chk({vecs[v].name, "_idle_outputs"}, {in_ready, busy, done, pb_sclk, pb_ssel}, 64'h0);
    end

    // Abort a frame after 100 bits, check the async clear, then reload.
    e0 = edges0;
    c  = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h11;
    while (edges0 - e0 < 100 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("midframe_reached_bit100", edges0 - e0, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {in_ready, busy, done, pb_sclk, pb_ssel, pb_sin, rd_valid, rd_data}, 64'h0);
    e0 = edges0;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midframe_reset_no_edge", edges0 - e0, 0);
    chk("midframe_reset_held", {in_ready, busy, done, pb_sclk, pb_ssel, pb_sin}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'h40, 8'h01, -1, 0, 1'b0, 1'b0, len, ndone, stall_bad, ssel_bad, nedges, rv_cnt, rv_bad);
    chk("restart_len", len, 1056);
    chk("restart_byte31", chain0[255:248], 8'h40);
    chk("restart_byte0", chain0[7:0], 8'h5F);
    check_contents("restart", 8'h40, 8'h01);
    chk("restart_done_pulses", ndone, 1);

    // CLK_DIV=1: serial clock toggles every shift cycle, 256 rising edges per frame.
    e0 = edges1; c = 0; first = -1; dc = -1; tog_bad = 0; prev_shift = 1'b0; prev_sclk = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    while (dc < 0 && c < 3000) begin
      if (in_ready1 === 1'b1 && first < 0) first = c;
      if (busy1 === 1'b1 && in_ready1 === 1'b0) begin
        if (prev_shift && pb_sclk1 === prev_sclk) tog_bad++;
        prev_shift = 1'b1;
      end else begin
        prev_shift = 1'b0;
      end
      prev_sclk = pb_sclk1;
      if (done1 === 1'b1) dc = c;
      @(negedge clk);
      c++;
    end
    chk("div1_len", (dc >= 0 && first >= 0) ? dc - first : -1, 544);
    chk("div1_sclk_edges", edges1 - e0, 256);
    chk("div1_toggle_misses", tog_bad, 0);
    chk("div1_contents", (chain1 === {32{8'h5A}}) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
